// File: rtl/alu_bist_ctrl.sv
// Self-test sequencer for the MyALU / MyALU2 pair.
// LFSR operands, opcode sweep 0..7, response compare and error log.
module alu_bist_ctrl #(
  parameter int              WIDTH      = 16,
  parameter int              VEC_PER_OP = 2,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int              SETTLE     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] in_n,
  output logic             in_c,
  output logic [2:0]       opc,
  input  logic [WIDTH-1:0] f1,
  input  logic             zer1,
  input  logic             neg1,
  input  logic [WIDTH-1:0] f2,
  input  logic             zer2,
  input  logic             neg2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [7:0]       first_err_idx,
  output logic             first_err_valid
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [4:0]       r_vec;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_in_m;
  logic [WIDTH-1:0] r_in_n;
  logic             r_in_c;
  logic [2:0]       r_opc;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_err;
  logic [7:0]       r_fei;
  logic             r_fev;

  logic [WIDTH-1:0] w_step1;
  logic [WIDTH-1:0] w_step2;
  logic             w_mis;
  logic             w_last_vec;
  logic [7:0]       w_idx;

  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] x
  );
    return {x[WIDTH-2:0],
            x[WIDTH-1] ^ x[WIDTH-3] ^ x[WIDTH-4] ^ x[WIDTH-6]};
  endfunction

  // Operand generation and response compare are pure functions of state.
  always_comb begin
    w_step1    = f_step(r_lfsr);
    w_step2    = f_step(w_step1);
    w_mis      = {f1, zer1, neg1} != {f2, zer2, neg2};
    w_last_vec = (r_vec == 5'(VEC_PER_OP - 1));
    w_idx      = 8'(r_opc) * 8'(VEC_PER_OP) + 8'(r_vec);
  end

  // Sequencer: one FSM owns every register so outputs stay glitch-free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= '0;
      r_vec   <= '0;
      r_cnt   <= '0;
      r_in_m  <= '0;
      r_in_n  <= '0;
      r_in_c  <= 1'b0;
      r_opc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= '0;
      r_fei   <= '0;
      r_fev   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_opc   <= '0;
            r_vec   <= '0;
            r_lfsr  <= SEED;
            r_err   <= '0;
            r_fev   <= 1'b0;
            r_fei   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_in_m  <= r_lfsr;
          r_in_n  <= w_step1;
          r_in_c  <= w_step1[WIDTH-1];
          r_lfsr  <= w_step2;
          r_cnt   <= CW'(SETTLE);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_mis) begin
            if (r_err != 8'hFF) r_err <= r_err + 8'd1;
            if (!r_fev) begin
              r_fev <= 1'b1;
              r_fei <= w_idx;
            end
          end
          if (w_last_vec && r_opc == 3'd7) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_last_vec) begin
            r_vec   <= '0;
            r_opc   <= r_opc + 3'd1;
            r_state <= S_LOAD;
          end else begin
            r_vec   <= r_vec + 5'd1;
            r_state <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output mapping; pass is derived from the registered result.
  always_comb begin
    in_m            = r_in_m;
    in_n            = r_in_n;
    in_c            = r_in_c;
    opc             = r_opc;
    busy            = r_busy;
    done            = r_done;
    err_count       = r_err;
    first_err_idx   = r_fei;
    first_err_valid = r_fev;
    pass            = r_done & (r_err == 8'd0);
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: reference ALU pair with fault modes,
// table of runs plus hand sequences for reset, held start and SETTLE.
module tb_alu_bist_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in_m, in_n;
  logic        in_c;
  logic [2:0]  opc;
  logic [15:0] f1, f2;
  logic        zer1, neg1, zer2, neg2;
  logic        busy, done, pass, fev;
  logic [7:0]  err_count, fei;

  logic        start_s = 1'b0;
  logic [15:0] m_s, n_s, f_s;
  logic        c_s, z_s, ng_s;
  logic [2:0]  o_s;
  logic        busy_s, done_s, pass_s, fev_s;
  logic [7:0]  err_s, fei_s;

  int mode = 0;
  int checks = 0;
  int errors = 0;

  logic [15:0] cap_m1, cap_n1, cap_m2;
  logic        cap_c1;
  logic [2:0]  cap_o1;

  always #5 clk = ~clk;

  alu_bist_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_m(in_m), .in_n(in_n), .in_c(in_c), .opc(opc),
    .f1(f1), .zer1(zer1), .neg1(neg1),
    .f2(f2), .zer2(zer2), .neg2(neg2),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(fei),
    .first_err_valid(fev)
  );

  alu_bist_ctrl #(.VEC_PER_OP(1), .SETTLE(3)) u_s (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .in_m(m_s), .in_n(n_s), .in_c(c_s), .opc(o_s),
    .f1(f_s), .zer1(z_s), .neg1(ng_s),
    .f2(f_s), .zer2(z_s), .neg2(ng_s),
    .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_count(err_s), .first_err_idx(fei_s),
    .first_err_valid(fev_s)
  );

  function automatic logic [17:0] alu(
    input logic [15:0] m, input logic [15:0] n,
    input logic c, input logic [2:0] op
  );
    logic [15:0] r;
    case (op)
      3'd0: r = m + n + 16'(c);
      3'd1: r = m - n - 16'(c);
      3'd2: r = m & n;
      3'd3: r = m | n;
      3'd4: r = m ^ n;
      3'd5: r = ~m;
      3'd6: r = m << 1;
      default: r = n;
    endcase
    return {r, r == 16'd0, r[15]};
  endfunction

  logic [17:0] w_r, w_rs;
  always_comb begin
    w_r  = alu(in_m, in_n, in_c, opc);
    f1   = w_r[17:2];
    zer1 = w_r[1];
    neg1 = w_r[0];
    f2   = (mode == 2) ? ~w_r[17:2] : w_r[17:2];
    zer2 = w_r[1];
    neg2 = (mode == 1 && opc == 3'd5) ? ~w_r[0] : w_r[0];
    w_rs = alu(m_s, n_s, c_s, o_s);
    f_s  = w_rs[17:2];
    z_s  = w_rs[1];
    ng_s = w_rs[0];
  end

  typedef struct {
    int   mode;
    bit   hold;
    int   err;
    bit   fev;
    int   idx;
    bit   pass;
    int   edge_n;
  } row_t;

  row_t rows[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, a, e);
    end
  endtask

  // Accept edge counts as edge 1; returns edge at which done is seen.
  task automatic run(input int md, input bit hold, output int de);
    mode  = md;
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    de = 0;
    for (int e = 2; e <= 200; e++) begin
      tick();
      if (e == 2) begin
        cap_m1 = in_m;
        cap_n1 = in_n;
        cap_c1 = in_c;
        cap_o1 = opc;
      end
      if (e == 5) cap_m2 = in_m;
      if (done) begin
        de = e;
        break;
      end
    end
  endtask

  task automatic check_row(input row_t r, input int de);
    chk("done_edge", 32'(de), 32'(r.edge_n));
    chk("in_m_v0", 32'(cap_m1), 32'h0000ACE1);
    chk("in_n_v0", 32'(cap_n1), 32'h000059C3);
    chk("in_c_v0", 32'(cap_c1), 32'd0);
    chk("opc_v0", 32'(cap_o1), 32'd0);
    chk("in_m_v1", 32'(cap_m2), 32'h0000B387);
    chk("err_count", 32'(err_count), 32'(r.err));
    chk("first_err_valid", 32'(fev), 32'(r.fev));
    chk("first_err_idx", 32'(fei), 32'(r.idx));
    chk("pass", 32'(pass), 32'(r.pass));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_m"}, 32'(in_m), 32'd0);
    chk({tag, "_in_n"}, 32'(in_n), 32'd0);
    chk({tag, "_in_c"}, 32'(in_c), 32'd0);
    chk({tag, "_opc"}, 32'(opc), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fei"}, 32'(fei), 32'd0);
    chk({tag, "_fev"}, 32'(fev), 32'd0);
  endtask

  initial begin
    int de;
    int nb;
    rows[0] = '{0, 1'b0, 0, 1'b0, 0, 1'b1, 49};
    rows[1] = '{1, 1'b0, 2, 1'b1, 10, 1'b0, 49};
    rows[2] = '{2, 1'b0, 16, 1'b1, 0, 1'b0, 49};
    rows[3] = '{1, 1'b1, 2, 1'b1, 10, 1'b0, 49};

    rst_n = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();
    check_zero("idle");

    for (int i = 0; i < 4; i++) begin
      run(rows[i].mode, rows[i].hold, de);
      check_row(rows[i], de);
      if (rows[i].hold) begin
        tick();
        chk("hold_restart_done", 32'(done), 32'd0);
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_err", 32'(err_count), 32'd0);
        chk("hold_restart_fev", 32'(fev), 32'd0);
        start = 1'b0;
        de = 0;
        for (int e = 0; e < 200; e++) begin
          tick();
          if (done) begin
            de = 1;
            break;
          end
        end
        chk("hold_second_done", 32'(de), 32'd1);
        chk("hold_second_err", 32'(err_count), 32'd2);
      end
    end

    mode  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 2; e <= 20; e++) tick();
    chk("mid_opc", 32'(opc), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_zero("midrst");
    tick();
    check_zero("midrst_idle");
    run(0, 1'b0, de);
    check_row(rows[0], de);

    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    nb = 0;
    de = 0;
    if (busy_s) nb++;
    for (int e = 2; e <= 300; e++) begin
      tick();
      if (busy_s) nb++;
      if (done_s) begin
        de = e;
        break;
      end
    end
    chk("s3_done_edge", 32'(de), 32'd41);
    chk("s3_busy_cycles", 32'(nb), 32'd40);
    chk("s3_pass", 32'(pass_s), 32'd1);
    chk("s3_err", 32'(err_s), 32'd0);
    chk("s3_last_opc", 32'(o_s), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
